i_arith_encoder: RTL and testbench
==================================

# i_arith_encoder

Streaming encoder for LEGv8 I-format arithmetic instructions (ADDI/ADDIS/SUBI/SUBIS), the inverse of the I-arithmetic decode path.
- Accepts one field-level request per handshake and produces the 32-bit instruction word.
- Writes consecutive words into instruction RAM through a word-write port with backpressure.
- Sits between the test/boot program loader and instruction memory, so programs can be built from fields rather than hand-packed hex.

## Interface
Parameters:
- ADDR_W, 16, width of the instruction-memory byte address.
- BASE_ADDR, 0, first write address after reset or rewind; must be a multiple of 4.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request can be taken this cycle.
- in_sub  in  1  0 = ADD, 1 = SUB.
- in_setflags  in  1  1 = flag-setting form (ADDIS/SUBIS).
- in_rd  in  5  destination register, encoded into bits [4:0].
- in_rn  in  5  source register, encoded into bits [9:5].
- in_imm  in  16  signed two's-complement immediate.
- addr_rewind  in  1  return the write pointer to BASE_ADDR.
- mem_we  out  1  write request to instruction RAM.
- mem_ready  in  1  RAM accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  32  encoded instruction.
- err  out  1  one-cycle pulse when a request is rejected.
- err_count  out  8  saturating count of rejected requests.
- words_written  out  16  wrapping count of completed memory writes.

## Operation
- **Request acceptance:** a request is taken when in_valid && in_ready.
  - in_ready = !reset && (fifo_count < 2).
  - There is no pass-through when the FIFO is full.
- **Immediate normalisation:**
  - If in_imm ≥ 0: mag = in_imm, eff_sub = in_sub.
  - If in_imm < 0: mag = -in_imm, eff_sub = !in_sub.
  - A request is legal iff mag ≤ 4095.
  - in_imm = -32768 is illegal, because its magnitude is not representable.
- **Encoding:** word[31] = 1, [30] = eff_sub, [29] = in_setflags, [28:22] = 7'b1000100, [21:10] = mag[11:0], [9:5] = in_rn, [4:0] = in_rd.
- **Legal requests** are pushed into a 2-entry FIFO holding the encoded word.
- **Illegal requests:**
  - The handshake still completes and the request is discarded.
  - err pulses high for exactly the following cycle.
  - err_count increments and saturates at 255.
- **Memory write:**
  - mem_we = (fifo_count ≠ 0); mem_wdata = FIFO head; mem_addr = write pointer.
  - A write transfers when mem_we && mem_ready. On transfer the head is popped, the pointer advances by 4 and words_written increments.
  - mem_addr and mem_wdata stay stable while mem_we is high and mem_ready is low.
- **Wrap rules:**
  - The pointer wraps modulo 2^ADDR_W.
  - words_written wraps at 2^16.
- **FIFO count update:** fifo_count' = fifo_count + push − pop. A simultaneous push and pop at count 1 keeps count at 1, and the new word becomes head after the pop.
- **addr_rewind:**
  - Pointer ← BASE_ADDR on the next edge, and the rewind overrides the +4 increment.
  - A transfer in the same cycle still uses the old address.
  - FIFO contents and both counters are untouched.

## Timing
- **Reset values** (at the first edge with reset high):
  - fifo_count = 0; mem_we = 0; mem_addr = BASE_ADDR; mem_wdata = 0.
  - err = 0; err_count = 0; words_written = 0; in_ready = 0 while reset is high.
- **Reset mid-operation:** a reset arriving while operation is in progress discards FIFO contents; there is no partial write.
- **Latency:** a request accepted at edge N appears with mem_we = 1 in cycle N+1, provided the FIFO was empty.
- **Throughput:** one word per cycle while mem_ready is held high.
- **Backpressure:** with mem_ready low, two requests are buffered, then in_ready drops. in_ready rises the cycle after the first pop.
- **err:** registered; high the cycle after the rejecting handshake. Back-to-back illegal requests hold err high continuously.

## Test plan
- **Basic ADDI:** reset, mem_ready = 1; request sub=0, S=0, rd=1, rn=2, imm=5 -> next cycle mem_we = 1, mem_addr = 0x0000, mem_wdata = 0x91001441; words_written = 1.
- **Flag form at immediate limit:** sub=1, S=1, rd=3, rn=4, imm=4095 -> 0xF13FFC83.
- **Negative immediates:**
  - sub=0, rd=1, rn=2, imm=-5 -> 0xD1001441 (SUBI #5).
  - sub=1, same fields -> 0x91001441.
- **Illegal immediates:** imm=4096, then imm=-32768 -> both handshakes complete, no mem_we, err high for two consecutive cycles, err_count = 2.
- **Backpressure:** mem_ready = 0; offer three legal requests ->
  - two accepted, then in_ready = 0.
  - mem_addr/mem_wdata stable while stalled.
  - When mem_ready = 1, writes land at 0x0, 0x4, 0x8 in order.
- **Rewind coincident with a write:** addr_rewind asserted in the same cycle as a transfer at 0x8 -> that write uses 0x8, the next write uses BASE_ADDR; reset asserted with a full FIFO -> mem_we = 0 next cycle.

Source files
------------

// File: rtl/i_arith_encoder.sv
// Streaming encoder for LEGv8 I-format ADDI/ADDIS/SUBI/SUBIS: packs field-level requests into
// 32-bit words, buffers them in a 2-entry FIFO and streams them into instruction RAM.
module i_arith_encoder #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sub,
    input  logic              in_setflags,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [15:0]       in_imm,
    input  logic              addr_rewind,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [15:0]       words_written
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic [1:0]        count_q, count_d;
    logic [31:0]       head_q, head_d;
    logic [31:0]       tail_q, tail_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              err_q;
    logic [7:0]        err_count_q;
    logic [15:0]       words_q;

    logic        imm_neg;
    logic [15:0] mag;
    logic        eff_sub;
    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        reject;
    logic        pop;

    // A negative immediate flips ADD<->SUB; -32768 negates to 0x8000 and so fails the range test.
    always_comb begin
        imm_neg = in_imm[15];
        mag     = imm_neg ? (~in_imm + 16'd1) : in_imm;
        eff_sub = in_sub ^ imm_neg;
        legal   = (mag[15:12] == 4'd0);
        word    = {1'b1, eff_sub, in_setflags, 7'b1000100, mag[11:0], in_rn, in_rd};
    end

    assign in_ready = !reset && (count_q != 2'd2);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign reject   = accept && !legal;
    assign pop      = (count_q != 2'd0) && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end
        // Push at count 1 with a pop lands directly in the head slot being vacated.
        if (push) begin
            if ((count_q == 2'd0) || pop) begin
                head_d = word;
            end else begin
                tail_d = word;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (addr_rewind) begin
            ptr_d = BaseAddr;
        end else if (pop) begin
            ptr_d = ptr_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= 2'd0;
            head_q      <= 32'd0;
            tail_q      <= 32'd0;
            ptr_q       <= BaseAddr;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            words_q     <= 16'd0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ptr_q   <= ptr_d;
            err_q   <= reject;
            if (reject && (err_count_q != 8'hff)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (pop) begin
                words_q <= words_q + 16'd1;
            end
        end
    end

    assign mem_we        = (count_q != 2'd0);
    assign mem_addr      = ptr_q;
    assign mem_wdata     = head_q;
    assign err           = err_q;
    assign err_count     = err_count_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_i_arith_encoder.sv
// Self-checking bench for i_arith_encoder: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_i_arith_encoder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned BASE   = 0;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sub = 1'b0;
    logic              in_setflags = 1'b0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_rn = 5'd0;
    logic [15:0]       in_imm = 16'd0;
    logic              addr_rewind = 1'b0;
    logic              mem_ready = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic [7:0]        err_count;
    logic [15:0]       words_written;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0]       mq[$];
    logic [ADDR_W-1:0] m_ptr = ADDR_W'(BASE);
    logic              m_err = 1'b0;
    int                m_errcnt = 0;
    logic [15:0]       m_ww = 16'd0;

    i_arith_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub       (in_sub),
        .in_setflags  (in_setflags),
        .in_rd        (in_rd),
        .in_rn        (in_rn),
        .in_imm       (in_imm),
        .addr_rewind  (addr_rewind),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .err          (err),
        .err_count    (err_count),
        .words_written(words_written)
    );

    always #5 clock = ~clock;

    function automatic void ref_encode(input logic sub, input logic s, input logic [4:0] rd,
                                       input logic [4:0] rn, input logic [15:0] imm,
                                       output logic legal, output logic [31:0] w);
        int v;
        int mag;
        int unsigned acc;
        logic es;
        v = int'($signed(imm));
        if (v < 0) begin
            mag = -v;
            es  = !sub;
        end else begin
            mag = v;
            es  = sub;
        end
        legal = (mag <= 4095);
        acc = 32'h8000_0000 + (es ? 32'h4000_0000 : 32'h0) + (s ? 32'h2000_0000 : 32'h0)
            + 32'h44 * 32'h40_0000 + int'(unsigned'(mag % 4096)) * 1024
            + int'(rn) * 32 + int'(rd);
        w = acc;
    endfunction

    task automatic model_edge();
        logic        acc;
        logic        legal;
        logic [31:0] w;
        logic [31:0] tmp;
        if (reset) begin
            mq.delete();
            m_ptr    = ADDR_W'(BASE);
            m_err    = 1'b0;
            m_errcnt = 0;
            m_ww     = 16'd0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            ref_encode(in_sub, in_setflags, in_rd, in_rn, in_imm, legal, w);
            if ((mq.size() != 0) && mem_ready) begin
                tmp   = mq.pop_front();
                m_ww  = m_ww + 16'd1;
                m_ptr = m_ptr + ADDR_W'(4);
            end
            if (addr_rewind) m_ptr = ADDR_W'(BASE);
            if (acc && legal) mq.push_back(w);
            m_err = acc && !legal;
            if (acc && !legal && (m_errcnt < 255)) m_errcnt++;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic set_req(input logic v, input logic sub, input logic s, input logic [4:0] rd,
                           input logic [4:0] rn, input logic [15:0] imm);
        in_valid    = v;
        in_sub      = sub;
        in_setflags = s;
        in_rd       = rd;
        in_rn       = rn;
        in_imm      = imm;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, BASE); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        n_cmp++; if (words_written !== 16'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_written); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_addi();
        mem_ready = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 16'd5);
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL addi_mem_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL addi_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h9100_1441) begin n_fail++; $display("FAIL addi_wdata: got %h want 91001441", mem_wdata); end
        cycle();
        n_cmp++; if (words_written !== 16'd1) begin n_fail++; $display("FAIL addi_words: got %0d want 1", words_written); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", mem_we); end
    endtask

    task automatic test_flag_limit();
        set_req(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 16'd4095);
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_wdata !== 32'hF13F_FC83) begin n_fail++; $display("FAIL subis_limit_wdata: got %h want F13FFC83", mem_wdata); end
        n_cmp++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL subis_limit_addr: got %h want 0004", mem_addr); end
        cycle();
    endtask

    task automatic test_negative();
        set_req(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 16'hFFFB);
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_wdata !== 32'hD100_1441) begin n_fail++; $display("FAIL neg_addi_wdata: got %h want D1001441", mem_wdata); end
        n_cmp++; if (mem_addr !== 16'h0008) begin n_fail++; $display("FAIL neg_addi_addr: got %h want 0008", mem_addr); end
        cycle();
        set_req(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 16'hFFFB);
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_wdata !== 32'h9100_1441) begin n_fail++; $display("FAIL neg_subi_wdata: got %h want 91001441", mem_wdata); end
        n_cmp++; if (mem_addr !== 16'h000C) begin n_fail++; $display("FAIL neg_subi_addr: got %h want 000C", mem_addr); end
        cycle();
        n_cmp++; if (words_written !== 16'd4) begin n_fail++; $display("FAIL neg_words: got %0d want 4", words_written); end
    endtask

    task automatic test_illegal();
        set_req(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 16'd4096);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_in_ready: got %b want 1", in_ready); end
        cycle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err1: got %b want 1", err); end
        n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_cnt1: got %0d want 1", err_count); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL illegal_we1: got %b want 0", mem_we); end
        in_imm = 16'h8000;
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err2: got %b want 1", err); end
        n_cmp++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL illegal_cnt2: got %0d want 2", err_count); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL illegal_we2: got %b want 0", mem_we); end
        cycle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b want 0", err); end
        n_cmp++; if (words_written !== 16'd4) begin n_fail++; $display("FAIL illegal_words: got %0d want 4", words_written); end
    endtask

    task automatic test_backpressure_rewind();
        logic [31:0] w[3];
        logic [4:0]  rd[3];
        logic [4:0]  rn[3];
        logic [15:0] imm[3];
        logic        sb[3];
        logic        sf[3];
        logic        lg;
        for (int i = 0; i < 3; i++) begin
            rd[i]  = 5'($urandom_range(0, 31));
            rn[i]  = 5'($urandom_range(0, 31));
            imm[i] = 16'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) imm[i] = -imm[i];
            sb[i]  = 1'($urandom_range(0, 1));
            sf[i]  = 1'($urandom_range(0, 1));
            ref_encode(sb[i], sf[i], rd[i], rn[i], imm[i], lg, w[i]);
        end
        addr_rewind = 1'b1;
        cycle();
        addr_rewind = 1'b0;
        n_cmp++; if (mem_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL rewind_idle: got %h want %h", mem_addr, BASE); end
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, sb[i], sf[i], rd[i], rn[i], imm[i]);
            cycle();
        end
        set_req(1'b1, sb[2], sf[2], rd[2], rn[2], imm[2]);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h0 || mem_wdata !== w[0]) begin
                n_fail++; $display("FAIL bp_stall%0d: got we=%b addr=%h data=%h want 1/0000/%h", i, mem_we, mem_addr, mem_wdata, w[0]);
            end
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        n_cmp++; if (mem_addr !== 16'h4 || mem_wdata !== w[1]) begin n_fail++; $display("FAIL bp_second: got %h/%h want 0004/%h", mem_addr, mem_wdata, w[1]); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h8 || mem_wdata !== w[2]) begin
            n_fail++; $display("FAIL bp_third: got we=%b %h/%h want 1/0008/%h", mem_we, mem_addr, mem_wdata, w[2]);
        end
        addr_rewind = 1'b1;
        cycle();
        addr_rewind = 1'b0;
        n_cmp++; if (mem_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL rewind_write_addr: got %h want %h", mem_addr, BASE); end
        n_cmp++; if (words_written !== 16'd7) begin n_fail++; $display("FAIL rewind_words: got %0d want 7", words_written); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rewind_we: got %b want 0", mem_we); end
        mem_ready = 1'b0;
        set_req(1'b1, sb[0], sf[0], rd[0], rn[0], imm[0]);
        cycle();
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_before_reset: got we=%b rdy=%b want 1/0", mem_we, in_ready); end
        reset = 1'b1;
        cycle();
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_full_we: got %b want 0", mem_we); end
        reset = 1'b0;
        mem_ready = 1'b1;
        cycle();
        n_cmp++; if (mem_we !== 1'b0 || words_written !== 16'd0) begin n_fail++; $display("FAIL reset_full_after: got we=%b words=%0d want 0/0", mem_we, words_written); end
    endtask

    task automatic test_err_saturate();
        mem_ready = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 16'h8000);
        for (int i = 0; i < 260; i++) begin
            cycle();
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err_hold%0d: got %b want 1", i, err); end
        end
        in_valid = 1'b0;
        n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", err_count); end
        cycle();
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 1500; i++) begin
            n_cmp++; if (in_ready !== (!reset && (mq.size() < 2))) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", i, in_ready, (!reset && (mq.size() < 2))); end
            n_cmp++; if (mem_we !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_mem_we@%0d: got %b want %b", i, mem_we, (mq.size() != 0)); end
            n_cmp++; if (mem_addr !== m_ptr) begin n_fail++; $display("FAIL rnd_mem_addr@%0d: got %h want %h", i, mem_addr, m_ptr); end
            if (mq.size() != 0) begin
                n_cmp++; if (mem_wdata !== mq[0]) begin n_fail++; $display("FAIL rnd_mem_wdata@%0d: got %h want %h", i, mem_wdata, mq[0]); end
            end
            n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", i, err, m_err); end
            n_cmp++; if (err_count !== 8'(m_errcnt)) begin n_fail++; $display("FAIL rnd_err_count@%0d: got %0d want %0d", i, err_count, m_errcnt); end
            n_cmp++; if (words_written !== m_ww) begin n_fail++; $display("FAIL rnd_words@%0d: got %0d want %0d", i, words_written, m_ww); end
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 2) != 0);
            in_sub      = 1'($urandom_range(0, 1));
            in_setflags = 1'($urandom_range(0, 1));
            in_rd       = 5'($urandom_range(0, 31));
            in_rn       = 5'($urandom_range(0, 31));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: in_imm = 16'($urandom_range(0, 4095));
                1: in_imm = -16'($urandom_range(0, 4095));
                2: in_imm = ($urandom_range(0, 1) == 1) ? 16'd4096 : 16'hF000;
                3: in_imm = 16'h8000;
                default: in_imm = 16'($urandom);
            endcase
            mem_ready   = ($urandom_range(0, 3) != 0);
            addr_rewind = ($urandom_range(0, 15) == 0);
            cycle();
        end
        reset       = 1'b0;
        in_valid    = 1'b0;
        addr_rewind = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic_addi();
        test_flag_limit();
        test_negative();
        test_illegal();
        test_backpressure_rewind();
        test_err_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
